// File: rtl/ats_egress_arbiter.sv
// Egress arbiter: grants one eligible ATS queue and forwards its whole frame before re-arbitrating.
// Optional ATS_ARB_EARLIEST_FIRST_EN: pick the smallest eligibility timestamp instead of strict priority.
module ats_egress_arbiter #(
    parameter int NUM_QUEUES      = 4,
    parameter int DATA_WIDTH      = 8,
    parameter int TIMESTAMP_WIDTH = 72,
    localparam int GW             = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [TIMESTAMP_WIDTH-1:0]            transmission_selection_timer,
    input  logic [NUM_QUEUES*DATA_WIDTH-1:0]      s_axis_tdata,
    input  logic [NUM_QUEUES-1:0]                 s_axis_tvalid,
    input  logic [NUM_QUEUES-1:0]                 s_axis_tlast,
    output logic [NUM_QUEUES-1:0]                 s_axis_tready,
    input  logic [NUM_QUEUES*TIMESTAMP_WIDTH-1:0] s_axis_eligibility_timestamp_tdata,
    input  logic [NUM_QUEUES-1:0]                 s_axis_eligibility_timestamp_tvalid,
    output logic [NUM_QUEUES-1:0]                 s_axis_eligibility_timestamp_tready,
    output logic [DATA_WIDTH-1:0]                 m_axis_tdata,
    output logic                                  m_axis_tvalid,
    output logic                                  m_axis_tlast,
    input  logic                                  m_axis_tready,
    output logic [GW-1:0]                         grant_queue,
    output logic                                  busy
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic [NUM_QUEUES-1:0] eligible;
    logic [GW-1:0]         winner;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            eligible[i] = s_axis_eligibility_timestamp_tvalid[i] & s_axis_tvalid[i] &
                (s_axis_eligibility_timestamp_tdata[i*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH]
                 <= transmission_selection_timer);
        end
    end

    // Ascending scan with strict '<' keeps the lowest index on ties.
`ifdef ATS_ARB_EARLIEST_FIRST_EN
    logic                       found;
    logic [TIMESTAMP_WIDTH-1:0] best_ts;
    always_comb begin
        winner  = '0;
        found   = 1'b0;
        best_ts = '0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (eligible[i] && (!found ||
                s_axis_eligibility_timestamp_tdata[i*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH] < best_ts)) begin
                winner  = GW'(i);
                best_ts = s_axis_eligibility_timestamp_tdata[i*TIMESTAMP_WIDTH +: TIMESTAMP_WIDTH];
                found   = 1'b1;
            end
        end
    end
`else
    logic found;
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_QUEUES; i++) begin
            if (eligible[i] && !found) begin
                winner = GW'(i);
                found  = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        m_axis_tdata                        = '0;
        m_axis_tvalid                       = 1'b0;
        m_axis_tlast                        = 1'b0;
        s_axis_tready                       = '0;
        s_axis_eligibility_timestamp_tready = '0;
        if (state_q == XFER) begin
            m_axis_tdata           = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
            m_axis_tvalid          = s_axis_tvalid[grant_q];
            m_axis_tlast           = s_axis_tlast[grant_q];
            s_axis_tready[grant_q] = m_axis_tready;
            // Timestamp is consumed exactly once, on the frame's final handshake.
            s_axis_eligibility_timestamp_tready[grant_q] =
                s_axis_tvalid[grant_q] & m_axis_tready & s_axis_tlast[grant_q];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = XFER;
                    grant_d = winner;
                    busy_d  = 1'b1;
                end
            end
            XFER: begin
                if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
        end
    end

    assign grant_queue = grant_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_ats_egress_arbiter.sv
// Directed bench for ats_egress_arbiter: per-queue frame sources, output beat recorder, scenario tasks.
module tb_ats_egress_arbiter;

    localparam int NQ = 4;
    localparam int DW = 8;
    localparam int TW = 72;

    logic              clk = 1'b0;
    logic              rst;
    logic [TW-1:0]     timer;
    logic [NQ*DW-1:0]  s_tdata;
    logic [NQ-1:0]     s_tvalid, s_tlast, s_tready;
    logic [NQ*TW-1:0]  ts_tdata;
    logic [NQ-1:0]     ts_tvalid, ts_tready;
    logic [DW-1:0]     m_tdata;
    logic              m_tvalid, m_tlast, m_tready;
    logic [1:0]        grant_queue;
    logic              busy;

    ats_egress_arbiter #(.NUM_QUEUES(NQ), .DATA_WIDTH(DW), .TIMESTAMP_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .transmission_selection_timer(timer),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
        .s_axis_eligibility_timestamp_tdata(ts_tdata), .s_axis_eligibility_timestamp_tvalid(ts_tvalid),
        .s_axis_eligibility_timestamp_tready(ts_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
        .grant_queue(grant_queue), .busy(busy)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Source side
    bit          act[NQ], tsen[NQ], ts_only[NQ];
    int          ptr[NQ], len[NQ], nfr[NQ], fidx[NQ];
    logic [TW-1:0] tsv[NQ];
    bit          rdy_rand = 0;
    // Observation side
    int optr[NQ], ofidx[NQ], beats[NQ], frames_out[NQ], ts_pulses[NQ];
    int bad_beats, bad_ts, frames_total, cyc, last_end, last_gap;
    int done_order[$];

    function automatic logic [7:0] mk(input int q, input int f, input int p);
        return 8'((q * 64) + ((f * 7 + p) % 64));
    endfunction

    task automatic drive();
        for (int q = 0; q < NQ; q++) begin
            s_tvalid[q]          = act[q];
            s_tlast[q]           = act[q] && (ptr[q] == len[q] - 1);
            s_tdata[q*DW +: DW]  = mk(q, fidx[q], ptr[q]);
            ts_tvalid[q]         = (act[q] && tsen[q]) || ts_only[q];
            ts_tdata[q*TW +: TW] = tsv[q];
        end
    endtask

    task automatic tick();
        bit fire[NQ];
        int g;
        @(negedge clk);
        if (m_tvalid && m_tready) begin
            g = int'(grant_queue);
            if (m_tdata !== mk(g, ofidx[g], optr[g]) || m_tlast !== (optr[g] == len[g] - 1) || busy !== 1'b1)
                bad_beats++;
            if (optr[g] == 0) last_gap = cyc - last_end;
            beats[g]++;
            if (optr[g] == len[g] - 1) begin
                optr[g] = 0;
                ofidx[g]++;
                frames_out[g]++;
                frames_total++;
                done_order.push_back(g);
                last_end = cyc;
            end else begin
                optr[g]++;
            end
        end
        for (int q = 0; q < NQ; q++) begin
            if (ts_tready[q]) begin
                ts_pulses[q]++;
                if (!(m_tvalid && m_tready && m_tlast && int'(grant_queue) == q)) bad_ts++;
            end
            fire[q] = s_tvalid[q] && s_tready[q];
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int q = 0; q < NQ; q++) begin
            if (fire[q]) begin
                if (ptr[q] == len[q] - 1) begin
                    fidx[q]++;
                    ptr[q] = 0;
                    if (nfr[q] > 0) nfr[q]--;
                    else act[q] = 0;
                end else begin
                    ptr[q]++;
                end
            end
        end
        if (rdy_rand) m_tready = 1'($urandom % 2);
        drive();
    endtask

    task automatic start_frame(input int q, input int l, input logic [TW-1:0] ts, input int extra);
        act[q] = 1; tsen[q] = 1; ptr[q] = 0; len[q] = l; tsv[q] = ts; nfr[q] = extra;
        drive();
    endtask

    task automatic clear_stats();
        for (int q = 0; q < NQ; q++) begin
            beats[q] = 0; frames_out[q] = 0; ts_pulses[q] = 0;
        end
        bad_beats = 0; bad_ts = 0; frames_total = 0;
        done_order.delete();
    endtask

    task automatic run_frames(input int target, input int budget, output bit timeout);
        int n = 0;
        while (frames_total < target && n < budget) begin
            tick();
            n++;
        end
        timeout = (frames_total < target);
    endtask

    task automatic test_reset();
        rst = 1; m_tready = 1; timer = '0;
        for (int q = 0; q < NQ; q++) begin
            act[q] = 0; tsen[q] = 0; ts_only[q] = 0; ptr[q] = 0; len[q] = 1; nfr[q] = 0;
            fidx[q] = 0; optr[q] = 0; ofidx[q] = 0; tsv[q] = '0;
        end
        drive();
        clear_stats();
        repeat (3) tick();
        #1;
        vec_cnt++;
        if ({m_tvalid, m_tlast, m_tdata, s_tready, ts_tready, grant_queue, busy} !== '0) begin
            err_cnt++;
            $display("FAIL reset_outputs got v=%b l=%b d=%h rdy=%b tsr=%b g=%0d busy=%b required all zero",
                     m_tvalid, m_tlast, m_tdata, s_tready, ts_tready, grant_queue, busy);
        end
        rst = 0;
        tick();
    endtask

    task automatic test_single_queue();
        bit to;
        clear_stats();
        timer = 72'h11;
        start_frame(1, 64, 72'h10, 0);
        run_frames(1, 500, to);
        vec_cnt++;
        if (to || beats[1] !== 64) begin
            err_cnt++; $display("FAIL single_beats got %0d required 64 (timeout=%0d)", beats[1], to);
        end
        vec_cnt++;
        if (ts_pulses[1] !== 1 || bad_ts !== 0) begin
            err_cnt++; $display("FAIL single_ts_pulse got %0d stray %0d required 1 stray 0", ts_pulses[1], bad_ts);
        end
        vec_cnt++;
        if (bad_beats !== 0) begin
            err_cnt++; $display("FAIL single_data got %0d bad beats required 0", bad_beats);
        end
        tick();
    endtask

    task automatic test_gating();
        bit to;
        clear_stats();
        timer = 72'h1F;
        start_frame(0, 6, 72'h20, 0);
        repeat (5) tick();
        #1;
        vec_cnt++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || beats[0] !== 0) begin
            err_cnt++; $display("FAIL gate_hold got busy=%b v=%b beats=%0d required 0 0 0", busy, m_tvalid, beats[0]);
        end
        timer = 72'h20;
        tick();
        #1;
        vec_cnt++;
        if (busy !== 1'b1 || grant_queue !== 2'd0 || m_tvalid !== 1'b1) begin
            err_cnt++; $display("FAIL gate_open got busy=%b g=%0d v=%b required 1 0 1", busy, grant_queue, m_tvalid);
        end
        run_frames(1, 200, to);
        vec_cnt++;
        if (to || beats[0] !== 6 || bad_beats !== 0 || ts_pulses[0] !== 1) begin
            err_cnt++; $display("FAIL gate_frame got beats=%0d bad=%0d ts=%0d required 6 0 1", beats[0], bad_beats, ts_pulses[0]);
        end
        tick();
    endtask

    task automatic test_contention();
        bit to;
        int e0, e1;
`ifdef ATS_ARB_EARLIEST_FIRST_EN
        e0 = 2; e1 = 0;
`else
        e0 = 0; e1 = 2;
`endif
        clear_stats();
        timer = 72'h40;
        start_frame(0, 4, 72'h30, 0);
        start_frame(2, 4, 72'h10, 0);
        run_frames(2, 200, to);
        vec_cnt++;
        if (to || done_order.size() != 2) begin
            err_cnt++; $display("FAIL contention_count got %0d frames required 2", done_order.size());
        end else if (done_order[0] !== e0 || done_order[1] !== e1) begin
            err_cnt++; $display("FAIL contention_order got %0d,%0d required %0d,%0d", done_order[0], done_order[1], e0, e1);
        end
        vec_cnt++;
        if (bad_beats !== 0 || bad_ts !== 0) begin
            err_cnt++; $display("FAIL contention_data got bad=%0d stray_ts=%0d required 0 0", bad_beats, bad_ts);
        end
        tick();
    endtask

    task automatic test_no_preempt();
        bit to;
        int n = 0;
        clear_stats();
        timer = 72'h100;
        start_frame(3, 8, 72'h0, 0);
        while (beats[3] < 4 && n < 100) begin tick(); n++; end
        start_frame(0, 5, 72'h0, 0);
        run_frames(2, 200, to);
        vec_cnt++;
        if (to || done_order.size() != 2) begin
            err_cnt++; $display("FAIL preempt_count got %0d frames required 2", done_order.size());
        end else if (done_order[0] !== 3 || done_order[1] !== 0) begin
            err_cnt++; $display("FAIL preempt_order got %0d,%0d required 3,0", done_order[0], done_order[1]);
        end
        vec_cnt++;
        if (last_gap !== 2 || bad_beats !== 0) begin
            err_cnt++; $display("FAIL preempt_gap got gap=%0d bad=%0d required 2 0", last_gap, bad_beats);
        end
        tick();
    endtask

    task automatic test_ineligible();
        bit to;
        clear_stats();
        timer = 72'h100;
        start_frame(1, 3, 72'h0, 0);
        tsen[1] = 0;
        ts_only[2] = 1;
        drive();
        repeat (5) tick();
        #1;
        vec_cnt++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0 || s_tready !== '0) begin
            err_cnt++; $display("FAIL half_valid got busy=%b v=%b rdy=%b required 0 0 0", busy, m_tvalid, s_tready);
        end
        ts_only[2] = 0;
        tsen[1] = 1;
        drive();
        run_frames(1, 100, to);
        vec_cnt++;
        if (to || beats[1] !== 3 || ts_pulses[1] !== 1 || ts_pulses[2] !== 0) begin
            err_cnt++; $display("FAIL half_valid_release got beats=%0d ts1=%0d ts2=%0d required 3 1 0", beats[1], ts_pulses[1], ts_pulses[2]);
        end
        tick();
    endtask

    task automatic test_backpressure();
        bit to;
        int lens[NQ] = '{5, 9, 13, 3};
        clear_stats();
        timer = 72'h1000;
        for (int q = 0; q < NQ; q++) start_frame(q, lens[q], 72'(q * 16), 4);
        rdy_rand = 1;
        run_frames(20, 4000, to);
        rdy_rand = 0;
        m_tready = 1;
        vec_cnt++;
        if (to || frames_total !== 20) begin
            err_cnt++; $display("FAIL bp_frames got %0d required 20", frames_total);
        end
        for (int q = 0; q < NQ; q++) begin
            vec_cnt++;
            if (frames_out[q] !== 5 || ts_pulses[q] !== 5 || beats[q] !== 5 * lens[q]) begin
                err_cnt++; $display("FAIL bp_queue%0d got frames=%0d ts=%0d beats=%0d required 5 5 %0d",
                                    q, frames_out[q], ts_pulses[q], beats[q], 5 * lens[q]);
            end
        end
        vec_cnt++;
        if (bad_beats !== 0 || bad_ts !== 0) begin
            err_cnt++; $display("FAIL bp_data got bad=%0d stray_ts=%0d required 0 0", bad_beats, bad_ts);
        end
        tick();
    endtask

    task automatic test_reset_mid_frame();
        bit to;
        int n = 0;
        clear_stats();
        timer = 72'h100;
        start_frame(2, 60, 72'h5, 0);
        while (beats[2] < 10 && n < 100) begin tick(); n++; end
        rst = 1;
        m_tready = 0;
        tick();
        #1;
        vec_cnt++;
        if ({m_tvalid, m_tlast, m_tdata, s_tready, ts_tready, grant_queue, busy} !== '0) begin
            err_cnt++;
            $display("FAIL midreset_outputs got v=%b l=%b d=%h rdy=%b tsr=%b g=%0d busy=%b required all zero",
                     m_tvalid, m_tlast, m_tdata, s_tready, ts_tready, grant_queue, busy);
        end
        vec_cnt++;
        if (ts_pulses[2] !== 0 || beats[2] !== 10) begin
            err_cnt++; $display("FAIL midreset_ts got ts=%0d beats=%0d required 0 10", ts_pulses[2], beats[2]);
        end
        rst = 0;
        m_tready = 1;
        ptr[2] = 0; optr[2] = 0; beats[2] = 0;
        drive();
        run_frames(1, 300, to);
        vec_cnt++;
        if (to || beats[2] !== 60 || ts_pulses[2] !== 1 || bad_beats !== 0) begin
            err_cnt++; $display("FAIL midreset_restart got beats=%0d ts=%0d bad=%0d required 60 1 0", beats[2], ts_pulses[2], bad_beats);
        end
        tick();
    endtask

    initial begin
        cyc = 0; last_end = 0; last_gap = 0;
        test_reset();
        test_single_queue();
        test_gating();
        test_contention();
        test_no_preempt();
        test_ineligible();
        test_backpressure();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
